sr_ff_bank: RTL and testbench

SR_FF_BANK -- requirements
Module: sr_ff_bank

---
 rtl/sr_ff_bank.sv | 118 +++++++++++
 tb/tb_sr_ff_bank.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of N independent edge-triggered SR flip-flops with configurable S=R=1 resolution,
// per-channel forbidden-input flags, a sticky error flag and a saturating event counter.
`timescale 1ns/1ps

module sr_ff_bank #(
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     R,
  input  logic             clr_err,
  output logic [N-1:0]     Q,
  output logic [N-1:0]     Qn,
  output logic [N-1:0]     forbidden,
  output logic             err_sticky,
  output logic [CNT_W-1:0] forb_cnt
);

  logic [N-1:0]     both;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     forbidden_reg;
  logic             err_reg;
  logic             err_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   pop_cnt;
  logic [CNT_W:0]   cnt_sum;

  assign both = S & R;

  // One fully independent flip-flop per channel; nothing here depends on N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      logic q_bit_reg;
      logic q_bit_next;

      always_comb begin
        q_bit_next = q_bit_reg;
        if (S[gi] && !R[gi]) begin
          q_bit_next = 1'b1;
        end else if (R[gi] && !S[gi]) begin
          q_bit_next = 1'b0;
        end else if (S[gi] && R[gi]) begin
          case (MODE)
            1:       q_bit_next = 1'b1;
            2:       q_bit_next = 1'b0;
            3:       q_bit_next = ~q_bit_reg;
            default: q_bit_next = q_bit_reg;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_bit_reg <= 1'b0;
        end else if (en) begin
          q_bit_reg <= q_bit_next;
        end
      end

      assign q_reg[gi] = q_bit_reg;
    end
  endgenerate

  // Count of channels with S=R=1 this cycle, kept one bit wider than the counter.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + {{CNT_W{1'b0}}, both[i]};
    end
  end

  assign cnt_sum = {1'b0, cnt_reg} + pop_cnt;

  // clr_err restarts the tally from this cycle's events so none are dropped.
  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (en) begin
      if (clr_err) begin
        cnt_next = pop_cnt[CNT_W-1:0];
        err_next = |both;
      end else begin
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        err_next = err_reg | (|both);
      end
    end else if (clr_err) begin
      cnt_next = '0;
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      forbidden_reg <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (en) begin
        forbidden_reg <= both;
      end
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign Q          = q_reg;
  assign Qn         = ~q_reg;
  assign forbidden  = forbidden_reg;
  assign err_sticky = err_reg;
  assign forb_cnt   = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: four MODE builds plus a CNT_W=4 build share stimulus and are
// compared against a behavioural model and against fixed expected values.
`timescale 1ns/1ps

module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_err;
  logic [3:0] S;
  logic [3:0] R;

  always #5 clk = ~clk;

  logic [3:0] q_d   [5];
  logic [3:0] qn_d  [5];
  logic [3:0] fb_d  [5];
  logic [7:0] cnt_d [5];
  logic       err_d [5];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      logic [3:0] q_w, qn_w, fb_w;
      logic [7:0] cnt_w;
      logic       err_w;
      sr_ff_bank #(.N(4), .MODE(gi), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .clr_err(clr_err),
        .Q(q_w), .Qn(qn_w), .forbidden(fb_w), .err_sticky(err_w), .forb_cnt(cnt_w)
      );
      assign q_d[gi]   = q_w;
      assign qn_d[gi]  = qn_w;
      assign fb_d[gi]  = fb_w;
      assign cnt_d[gi] = cnt_w;
      assign err_d[gi] = err_w;
    end
  endgenerate

  logic [3:0] sat_q, sat_qn, sat_fb;
  logic [3:0] sat_cnt;
  logic       sat_err;
  sr_ff_bank #(.N(4), .MODE(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .Q(sat_q), .Qn(sat_qn), .forbidden(sat_fb), .err_sticky(sat_err), .forb_cnt(sat_cnt)
  );
  assign q_d[4]   = sat_q;
  assign qn_d[4]  = sat_qn;
  assign fb_d[4]  = sat_fb;
  assign cnt_d[4] = {4'b0000, sat_cnt};
  assign err_d[4] = sat_err;

  // Behavioural reference model, one entry per instance.
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_mode [5] = '{0, 1, 2, 3, 0};
  int         m_max  [5] = '{255, 255, 255, 255, 15};
  logic [3:0] m_q    [5];
  logic [3:0] m_fb   [5];
  int         m_cnt  [5];
  bit         m_err  [5];

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_q[k] = 4'h0; m_fb[k] = 4'h0; m_cnt[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int pc;
    if (rst) begin
      model_reset();
      return;
    end
    pc = $countones(S & R);
    for (int k = 0; k < 5; k++) begin
      if (en) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (S[ch] && !R[ch])      m_q[k][ch] = 1'b1;
          else if (R[ch] && !S[ch]) m_q[k][ch] = 1'b0;
          else if (S[ch] && R[ch]) begin
            if (m_mode[k] == 1)      m_q[k][ch] = 1'b1;
            else if (m_mode[k] == 2) m_q[k][ch] = 1'b0;
            else if (m_mode[k] == 3) m_q[k][ch] = ~m_q[k][ch];
          end
        end
        m_fb[k] = S & R;
        if (clr_err) begin
          m_cnt[k] = pc;
          m_err[k] = (pc > 0);
        end else begin
          m_cnt[k] = (m_cnt[k] + pc > m_max[k]) ? m_max[k] : m_cnt[k] + pc;
          m_err[k] = m_err[k] | (pc > 0);
        end
      end else if (clr_err) begin
        m_cnt[k] = 0;
        m_err[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; S = 4'hF; R = 4'h0; clr_err = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'h0 || qn_d[k] !== 4'hF || fb_d[k] !== 4'h0 ||
          cnt_d[k] !== 8'd0 || err_d[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset k=%0d got q=%h qn=%h fb=%h cnt=%0d err=%b exp q=0 qn=f fb=0 cnt=0 err=0",
                 k, q_d[k], qn_d[k], fb_d[k], cnt_d[k], err_d[k]);
      end
    end
  endtask

  task automatic test_set_hold();
    rst = 1'b0; S = 4'b0001; R = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'b0001 || qn_d[k] !== 4'b1110) begin
        n_fail++;
        $display("FAIL set k=%0d got q=%b qn=%b exp q=0001 qn=1110", k, q_d[k], qn_d[k]);
      end
    end
    S = 4'b0000;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'b0001) begin
        n_fail++;
        $display("FAIL hold k=%0d got q=%b exp 0001", k, q_d[k]);
      end
    end
  endtask

  task automatic test_modes();
    bit exp1 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit exp2 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    S = 4'b0001; R = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k][0] !== exp1[k] || qn_d[k][0] !== ~exp1[k]) begin
        n_fail++;
        $display("FAIL mode_edge1 k=%0d got q0=%b qn0=%b exp q0=%b", k, q_d[k][0], qn_d[k][0], exp1[k]);
      end
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k][0] !== exp2[k] || fb_d[k][0] !== 1'b1 || err_d[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL mode_edge2 k=%0d got q0=%b fb0=%b err=%b exp q0=%b fb0=1 err=1",
                 k, q_d[k][0], fb_d[k][0], err_d[k], exp2[k]);
      end
    end
  endtask

  task automatic test_count_saturate();
    rst = 1'b1; tick(); rst = 1'b0;
    S = 4'hF; R = 4'hF;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== 8'd12) begin
        n_fail++;
        $display("FAIL count3 k=%0d got %0d exp 12", k, cnt_d[k]);
      end
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== ((k == 4) ? 8'd15 : 8'd16)) begin
        n_fail++;
        $display("FAIL count4 k=%0d got %0d exp %0d", k, cnt_d[k], (k == 4) ? 15 : 16);
      end
    end
    repeat (2) tick();
    n_checks++;
    if (cnt_d[4] !== 8'd15) begin
      n_fail++;
      $display("FAIL sat_hold got %0d exp 15", cnt_d[4]);
    end
  endtask

  task automatic test_clr_err();
    clr_err = 1'b1; S = 4'b0011; R = 4'b0011;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== 8'd2 || err_d[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_with_events k=%0d got cnt=%0d err=%b exp cnt=2 err=1", k, cnt_d[k], err_d[k]);
      end
    end
    S = 4'b0000; R = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== 8'd0 || err_d[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_quiet k=%0d got cnt=%0d err=%b exp cnt=0 err=0", k, cnt_d[k], err_d[k]);
      end
    end
    clr_err = 1'b0;
  endtask

  task automatic test_enable();
    S = 4'hF; R = 4'hF; en = 1'b1;
    tick();
    en = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== 8'd4 || fb_d[k] !== 4'hF || q_d[k] !== m_q[k] || err_d[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL en_freeze k=%0d got q=%b fb=%h cnt=%0d err=%b exp q=%b fb=f cnt=4 err=1",
                 k, q_d[k], fb_d[k], cnt_d[k], err_d[k], m_q[k]);
      end
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cnt_d[k] !== 8'd0 || err_d[k] !== 1'b0 || fb_d[k] !== 4'hF) begin
        n_fail++;
        $display("FAIL clr_while_disabled k=%0d got cnt=%0d err=%b fb=%h exp cnt=0 err=0 fb=f",
                 k, cnt_d[k], err_d[k], fb_d[k]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    rst = 1'b1; S = 4'h0; R = 4'h0; tick(); rst = 1'b0;
    S = 4'hF; R = 4'hF; tick();
    S = 4'h7; R = 4'h7; tick();
    S = 4'b1010; R = 4'b0101; tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'b1010 || cnt_d[k] !== 8'd7) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got q=%b cnt=%0d exp q=1010 cnt=7", k, q_d[k], cnt_d[k]);
      end
    end
    #2 rst = 1'b1;
    S = 4'hF; R = 4'h0;
    #1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'h0 || qn_d[k] !== 4'hF || cnt_d[k] !== 8'd0 || err_d[k] !== 1'b0 || fb_d[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL async_reset k=%0d got q=%b qn=%b cnt=%0d err=%b fb=%h exp q=0000 qn=1111 cnt=0 err=0 fb=0",
                 k, q_d[k], qn_d[k], cnt_d[k], err_d[k], fb_d[k]);
      end
    end
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL post_release_no_edge k=%0d got q=%b exp 0000", k, q_d[k]);
      end
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_d[k] !== 4'hF || qn_d[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL first_edge_after_release k=%0d got q=%b qn=%b exp q=1111 qn=0000", k, q_d[k], qn_d[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      S       = 4'($urandom);
      R       = 4'($urandom);
      en      = ($urandom_range(0, 9) < 8);
      clr_err = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 39) == 0);
      tick();
      $display("txn %0d rst=%b en=%b clr=%b S=%b R=%b q0..3=%b %b %b %b cnt0=%0d cnt_sat=%0d",
               t, rst, en, clr_err, S, R, q_d[0], q_d[1], q_d[2], q_d[3], cnt_d[0], cnt_d[4]);
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (q_d[k] !== m_q[k] || qn_d[k] !== ~m_q[k] || fb_d[k] !== m_fb[k] ||
            cnt_d[k] !== 8'(m_cnt[k]) || err_d[k] !== m_err[k]) begin
          n_fail++;
          $display("FAIL random t=%0d k=%0d got q=%b qn=%b fb=%b cnt=%0d err=%b exp q=%b qn=%b fb=%b cnt=%0d err=%b",
                   t, k, q_d[k], qn_d[k], fb_d[k], cnt_d[k], err_d[k],
                   m_q[k], ~m_q[k], m_fb[k], m_cnt[k], m_err[k]);
        end
      end
    end
    rst = 1'b0; en = 1'b1; clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; S = 4'h0; R = 4'h0;
    model_reset();
    test_reset();
    test_set_hold();
    test_modes();
    test_count_saturate();
    test_clr_err();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
